// File: rtl/key_debounce.sv
// Multi-channel key debouncer: per-channel sync, stability counter, edge pulses.
// Optional long-press pulse built when KEY_LONGPRESS_EN is defined.
module key_debounce #(
    parameter int N             = 4,
    parameter int STABLE_CYCLES = 500000,
    parameter int LONG_CYCLES   = 50000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] key,
    output logic [N-1:0] key_level,
    output logic [N-1:0] press_pulse,
    output logic [N-1:0] release_pulse,
    output logic [N-1:0] long_pulse
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    if (STABLE_CYCLES < 1 || LONG_CYCLES < 2 || N < 1) begin : g_bad_param
        $error("key_debounce: illegal parameter value");
    end

    logic [N-1:0]  s1_q, s2_q;
    logic [N-1:0]  state_q, state_d;
    logic [N-1:0]  level_q, level_d;
    logic [N-1:0]  press_q, press_d;
    logic [N-1:0]  release_q, release_d;
    logic [N-1:0]  flip;
    logic [CW-1:0] cnt_q [N];
    logic [CW-1:0] cnt_d [N];

    // state holds the synchronised raw (active-low) level; it flips only
    // after STABLE_CYCLES consecutive disagreeing samples
    always_comb begin
        flip      = '0;
        state_d   = state_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != state_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    flip[i]    = 1'b1;
                    state_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
            press_d[i]   = flip[i] & ~s2_q[i];
            release_d[i] = flip[i] & s2_q[i];
        end
        level_d = ~state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q      <= '1;
            s2_q      <= '1;
            state_q   <= '1;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < N; i++) cnt_q[i] <= '0;
        end else begin
            s1_q      <= key;
            s2_q      <= s1_q;
            state_q   <= state_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign key_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

`ifdef KEY_LONGPRESS_EN
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] HOLD_FIRE = HW'(LONG_CYCLES - 2);

    logic [HW-1:0] hc_q [N];
    logic [HW-1:0] hc_d [N];
    logic [N-1:0]  long_q, long_d;

    // fire on the edge hc steps to LONG_CYCLES-1; a release flip wins
    always_comb begin
        long_d = '0;
        for (int i = 0; i < N; i++) begin
            hc_d[i] = hc_q[i];
            if (press_d[i]) begin
                hc_d[i] = '0;
            end else if (!state_q[i] && hc_q[i] != HOLD_MAX) begin
                hc_d[i] = hc_q[i] + 1'b1;
            end
            long_d[i] = !state_q[i] && !flip[i] && (hc_q[i] == HOLD_FIRE);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            long_q <= '0;
            for (int i = 0; i < N; i++) hc_q[i] <= '0;
        end else begin
            long_q <= long_d;
            for (int i = 0; i < N; i++) hc_q[i] <= hc_d[i];
        end
    end

    assign long_pulse = long_q;
`else
    assign long_pulse = '0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Directed table-driven bench for key_debounce (N=4, STABLE=4, LONG=10).
module tb_key_debounce;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key;
    logic [3:0] key_level, press_pulse, release_pulse, long_pulse;

    always #5 clk = ~clk;

    key_debounce #(
        .N(4), .STABLE_CYCLES(4), .LONG_CYCLES(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key(key),
        .key_level(key_level),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .long_pulse(long_pulse)
    );

`ifdef KEY_LONGPRESS_EN
    localparam logic [3:0] LNG2 = 4'b0100;
`else
    localparam logic [3:0] LNG2 = 4'b0000;
`endif

    typedef struct {
        logic       r;
        logic [3:0] k;
        logic [3:0] lvl;
        logic [3:0] prs;
        logic [3:0] rel;
        logic [3:0] lng;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic add(input logic r, input logic [3:0] k, input logic [3:0] lvl,
                       input logic [3:0] prs, input logic [3:0] rel,
                       input logic [3:0] lng);
        vec_t v;
        v.r = r; v.k = k; v.lvl = lvl; v.prs = prs; v.rel = rel; v.lng = lng;
        tbl.push_back(v);
    endtask

    task automatic rep(input int n, input logic r, input logic [3:0] k,
                       input logic [3:0] lvl);
        for (int i = 0; i < n; i++) add(r, k, lvl, 4'h0, 4'h0, 4'h0);
    endtask

    task automatic check(input string nm, input logic [3:0] lvl,
                         input logic [3:0] prs, input logic [3:0] rel,
                         input logic [3:0] lng);
        n_vec++;
        if (key_level !== lvl || press_pulse !== prs ||
            release_pulse !== rel || long_pulse !== lng) begin
            n_err++;
            $display("FAIL %s: got lvl=%b prs=%b rel=%b lng=%b want lvl=%b prs=%b rel=%b lng=%b",
                     nm, key_level, press_pulse, release_pulse, long_pulse,
                     lvl, prs, rel, lng);
        end
    endtask

    initial begin
        // reset with all keys held, then press seen after reset exit
        rep(2, 0, 4'h0, 4'h0);
        rep(5, 1, 4'h0, 4'h0);
        add(1, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0);
        rep(1, 1, 4'h0, 4'hF);
        rep(5, 1, 4'hF, 4'hF);
        add(1, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0);
        rep(2, 1, 4'hF, 4'h0);
        // clean press and release on key 0
        rep(5, 1, 4'hE, 4'h0);
        add(1, 4'hE, 4'h1, 4'h1, 4'h0, 4'h0);
        rep(2, 1, 4'hE, 4'h1);
        rep(5, 1, 4'hF, 4'h1);
        add(1, 4'hF, 4'h0, 4'h0, 4'h1, 4'h0);
        rep(1, 1, 4'hF, 4'h0);
        // 3-cycle glitch on key 1: nothing
        rep(3, 1, 4'hD, 4'h0);
        rep(5, 1, 4'hF, 4'h0);
        // 4-cycle low on key 1: press, then release
        rep(4, 1, 4'hD, 4'h0);
        rep(1, 1, 4'hF, 4'h0);
        add(1, 4'hF, 4'h2, 4'h2, 4'h0, 4'h0);
        rep(3, 1, 4'hF, 4'h2);
        add(1, 4'hF, 4'h0, 4'h0, 4'h2, 4'h0);
        rep(1, 1, 4'hF, 4'h0);
        // key 2 released on the very edge long would fire
        rep(5, 1, 4'hB, 4'h0);
        add(1, 4'hB, 4'h4, 4'h4, 4'h0, 4'h0);
        rep(3, 1, 4'hB, 4'h4);
        rep(5, 1, 4'hF, 4'h4);
        add(1, 4'hF, 4'h0, 4'h0, 4'h4, 4'h0);
        rep(1, 1, 4'hF, 4'h0);
        // key 3 press, then key 0 press with key 3 release together
        rep(5, 1, 4'h7, 4'h0);
        add(1, 4'h7, 4'h8, 4'h8, 4'h0, 4'h0);
        rep(1, 1, 4'h7, 4'h8);
        rep(5, 1, 4'hE, 4'h8);
        add(1, 4'hE, 4'h1, 4'h1, 4'h8, 4'h0);
        rep(1, 1, 4'hE, 4'h1);
        rep(5, 1, 4'hF, 4'h1);
        add(1, 4'hF, 4'h0, 4'h0, 4'h1, 4'h0);
        rep(1, 1, 4'hF, 4'h0);
        // reset at cnt=2 on key 2, then normal-latency press and long press
        rep(4, 1, 4'hB, 4'h0);
        rep(2, 0, 4'hB, 4'h0);
        rep(5, 1, 4'hB, 4'h0);
        add(1, 4'hB, 4'h4, 4'h4, 4'h0, 4'h0);
        rep(8, 1, 4'hB, 4'h4);
        add(1, 4'hB, 4'h4, 4'h0, 4'h0, LNG2);
        rep(3, 1, 4'hB, 4'h4);

        rst = 1'b0;
        key = 4'hF;
        #2;
        check("reset_idle", 4'h0, 4'h0, 4'h0, 4'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].r;
            key = tbl[i].k;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), tbl[i].lvl, tbl[i].prs,
                  tbl[i].rel, tbl[i].lng);
        end

        // asynchronous reset while key 2 is held: outputs drop at once
        #2;
        rst = 1'b0;
        #1;
        check("async_rst", 4'h0, 4'h0, 4'h0, 4'h0);
        key = 4'hF;
        @(posedge clk);
        #1;
        check("rst_held", 4'h0, 4'h0, 4'h0, 4'h0);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("rst_exit%0d", i), 4'h0, 4'h0, 4'h0, 4'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/key_debounce.md
# key_debounce

Parametrised multi-channel push-button conditioner, the next generation of the board-level key debouncer. Each channel has a two-flop synchroniser and its own stability counter. Each channel produces a debounced level plus single-cycle press, release and (optionally) long-press pulses. It sits between the raw active-low board keys and the CPU's debug/step/control logic, all in the single system clock domain.

## Interface
- N, 4: number of independent key channels (≥1).
- STABLE_CYCLES, 500000: consecutive cycles a synchronised input must disagree with the debounced state before the state flips (≥1).
- LONG_CYCLES, 50000000: cycles after a press pulse at which the long-press pulse fires (≥2).
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  asynchronous, active-low reset.
- key  input  N  raw keys, active-low (0 = pressed), asynchronous to clk.
- key_level  output  N  debounced level, active-high (1 = pressed).
- press_pulse  output  N  one-cycle pulse when a channel becomes pressed.
- release_pulse  output  N  one-cycle pulse when a channel becomes released.
- long_pulse  output  N  one-cycle pulse on long press (see Configuration).

## Operation
- Reset (rst=0, asynchronous): synchroniser flops = all 1, debounced state = all 1 (released), all counters = 0, all outputs = 0.
- Per channel i, fully independent. There is no shared counter, unlike the single-counter debouncer it replaces.
- Synchroniser: s1 <= key[i]; s2 <= s1.
- Stability counter cnt, width $clog2(STABLE_CYCLES+1):
  - s2 == state: cnt <= 0.
  - s2 != state and cnt < STABLE_CYCLES-1: cnt <= cnt+1.
  - s2 != state and cnt == STABLE_CYCLES-1: state <= s2 and cnt <= 0. On the same edge, register press_pulse (new state 0) or release_pulse (new state 1).
- A glitch shorter than STABLE_CYCLES consecutive mismatch cycles clears cnt and produces no output activity.
- key_level[i] = ~state, registered; it changes on the same edge as the pulse.
- Long-press hold counter hc, width $clog2(LONG_CYCLES+1):
  - Cleared on the press edge.
  - Increments each cycle while state==0.
  - Saturates at LONG_CYCLES.
  - long_pulse asserts for one cycle exactly when hc reaches LONG_CYCLES-1 while state is still 0, so at most once per press.
- Simultaneous events:
  - Release flip on the same edge long would fire: the release wins and long_pulse is suppressed.
  - Different channels may pulse in the same cycle with no interaction.
- Reset mid-count or mid-hold aborts everything immediately. No pulse is emitted on reset exit, even if a key is held. A held key then produces press_pulse after the normal latency.

## Timing
- Raw key change set up before edge 0: s1 at edge 0, s2 at edge 1. Mismatch is counted on edges 2 … STABLE_CYCLES+1.
- The state flips and the pulse is registered at edge STABLE_CYCLES+1. The pulse is high for exactly the following cycle.
- long_pulse is high in cycle k+LONG_CYCLES-1, where press_pulse is high in cycle k.
- All outputs are registered, with no combinational path from key to outputs.
- press_pulse and release_pulse on one channel are never high in the same cycle.

## Configuration
- KEY_LONGPRESS_EN defined:
  - hold counters and long_pulse logic are built as described.
- KEY_LONGPRESS_EN undefined:
  - long_pulse is tied to 0 for all channels.
  - No hold counters are instantiated.
  - LONG_CYCLES is ignored.
  - All other behaviour is identical.

## Test plan
Bench parameters: N=4, STABLE_CYCLES=4, LONG_CYCLES=10, KEY_LONGPRESS_EN defined unless noted.
- Reset: hold rst=0 with key=4'b0000. All outputs read 0. Release rst. press_pulse=4'b1111 is high only in the cycle after edge 5 post-reset. key_level=4'b1111 from that cycle on.
- Clean press: key[0] 1→0 before edge 0, held. press_pulse[0] is high in the cycle after edge 5 only, and key_level[0] rises at edge 5. Releasing key[0] gives release_pulse[0] with the same 5-edge latency.
- Glitch: key[1] low for 3 cycles then high. No pulse and key_level[1] stays 0. Repeat with the key low for 4 synchronised cycles: press_pulse[1] fires.
- Long press: hold key[2] low. long_pulse[2] is high exactly 9 cycles after press_pulse[2], once only. Releasing at hold cycle 5 gives release_pulse and no long_pulse.
- Independence and simultaneity: key[0] pressed while key[3] is released, both on the same edge. press_pulse[0] and release_pulse[3] are high in the same cycle.
- Reset mid-operation and macro off: assert rst at cnt=2 → outputs 0 immediately, no pulse. Rebuild without KEY_LONGPRESS_EN: the long-press scenario gives long_pulse=0 throughout.
